// File: rtl/line_buf_ctrl_pkg.sv
// rtl/line_buf_ctrl_pkg.sv - shared state encoding, default geometry and helpers for line_buf_ctrl
package line_buf_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int DEF_LINE_LEN  = 640;
  localparam int DEF_NUM_LINES = 480;
  localparam int DEF_CX_W      = 10;
  localparam int DEF_CY_W      = 9;

  // Shifts needed before the centre tap holds pixel (0,0)
  function automatic int fill_cnt(input int line_len);
    return line_len + 2;
  endfunction

  function automatic logic is_border(input int x, input int y, input int len_x, input int len_y);
    return (x == 0) || (x == len_x - 1) || (y == 0) || (y == len_y - 1);
  endfunction

endpackage

// File: rtl/line_buf_ctrl_raster_cnt.sv
// rtl/line_buf_ctrl_raster_cnt.sv - raster x/y position counter with clear, advance, wrap and last flag
module line_buf_ctrl_raster_cnt
  import line_buf_ctrl_pkg::*;
#(
  parameter int LEN_X = DEF_LINE_LEN,
  parameter int LEN_Y = DEF_NUM_LINES,
  parameter int W_X   = DEF_CX_W,
  parameter int W_Y   = DEF_CY_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  output logic [W_X-1:0] x,
  output logic [W_Y-1:0] y,
  output logic           last,
  output logic           nxt_border
);

  logic [W_X-1:0] x_q, x_d, base_x;
  logic [W_Y-1:0] y_q, y_d, base_y;

  // clr and en together give the position after the first element
  always_comb begin
    base_x = clr ? '0 : x_q;
    base_y = clr ? '0 : y_q;
    x_d    = base_x;
    y_d    = base_y;
    if (en) begin
      if (base_x == W_X'(LEN_X - 1)) begin
        x_d = '0;
        y_d = (base_y == W_Y'(LEN_Y - 1)) ? '0 : base_y + W_Y'(1);
      end else begin
        x_d = base_x + W_X'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign last       = (x_q == W_X'(LEN_X - 1)) && (y_q == W_Y'(LEN_Y - 1));
  assign nxt_border = is_border(int'(x_d), int'(y_d), LEN_X, LEN_Y);

endmodule

// File: rtl/line_buf_ctrl.sv
// rtl/line_buf_ctrl.sv - 3x3 line buffer sequencer: shift/flush control, window centre tracking, border flag
// Optional frame counter built when FRAME_CNT_EN is defined.
module line_buf_ctrl
  import line_buf_ctrl_pkg::*;
#(
  parameter int LINE_LEN  = DEF_LINE_LEN,
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int CX_W      = DEF_CX_W,
  parameter int CY_W      = DEF_CY_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sof,
  input  logic            pix_valid,
  output logic            pix_ready,
  input  logic            win_ready,
  output logic            shift_en,
  output logic            flush,
  output logic            win_valid,
  output logic [CX_W-1:0] win_x,
  output logic [CY_W-1:0] win_y,
  output logic            border,
  output logic            frame_done,
  output logic            sof_err,
  output logic [15:0]     frame_cnt
);

  localparam int N        = LINE_LEN * NUM_LINES;
  localparam int FILL_CNT = fill_cnt(LINE_LEN);
  localparam int K_MAX    = N + FILL_CNT;
  localparam int K_W      = $clog2(N + LINE_LEN + 3);

  state_e         state_q, state_d;
  logic [K_W-1:0] k_q, k_d, k_inc;
  logic           run_q, run_d;
  logic           win_valid_q, win_valid_d;
  logic           border_q, border_d;
  logic           sof_err_q, sof_err_d;

  logic           accept, sof_acc, mid_frame, produce, in_en, win_en;
  logic [CX_W-1:0] in_x;
  logic [CY_W-1:0] in_y;
  logic           in_last, in_nb, win_last, win_nb;

  // run_q holds pix_ready low for the first cycle out of reset
  always_comb begin
    run_d     = 1'b1;
    pix_ready = 1'b0;
    case (state_q)
      ST_IDLE, ST_FILL: pix_ready = run_q;
      ST_STREAM:        pix_ready = run_q & win_ready;
      default:          pix_ready = 1'b0;
    endcase
  end

  assign accept    = pix_valid & pix_ready;
  assign sof_acc   = accept & sof;
  assign mid_frame = (state_q == ST_FILL) || (state_q == ST_STREAM) || (state_q == ST_FLUSH);
  assign flush     = (state_q == ST_FLUSH);
  assign shift_en  = (accept & ((state_q != ST_IDLE) | sof)) | (flush & win_ready);
  assign k_inc     = k_q + K_W'(1);
  assign produce   = shift_en & ~sof_acc & (k_inc >= K_W'(FILL_CNT)) & (k_inc < K_W'(K_MAX));
  assign in_en     = shift_en & ~flush;
  assign win_en    = produce & (k_inc != K_W'(FILL_CNT));

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    win_valid_d = win_valid_q;
    border_d    = border_q;
    sof_err_d   = sof_acc & mid_frame;

    if (sof_acc) begin
      k_d         = K_W'(1);
      win_valid_d = 1'b0;
      border_d    = 1'b0;
    end else if (shift_en) begin
      k_d         = k_inc;
      win_valid_d = produce;
      if (produce) border_d = win_nb;
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (sof_acc) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (sof_acc) state_d = ST_FILL;
        else if (shift_en && (k_inc == K_W'(FILL_CNT))) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (sof_acc) state_d = ST_FILL;
        else if (accept && in_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // the final flush shift retires window (LINE_LEN-1, NUM_LINES-1)
        if (shift_en && (k_inc == K_W'(K_MAX))) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        k_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      run_q       <= 1'b0;
      win_valid_q <= 1'b0;
      border_q    <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      run_q       <= run_d;
      win_valid_q <= win_valid_d;
      border_q    <= border_d;
      sof_err_q   <= sof_err_d;
    end
  end

  line_buf_ctrl_raster_cnt #(
    .LEN_X(LINE_LEN), .LEN_Y(NUM_LINES), .W_X(CX_W), .W_Y(CY_W)
  ) u_in_cnt (
    .clk(clk), .rst_n(rst), .clr(sof_acc), .en(in_en),
    .x(in_x), .y(in_y), .last(in_last), .nxt_border(in_nb)
  );

  line_buf_ctrl_raster_cnt #(
    .LEN_X(LINE_LEN), .LEN_Y(NUM_LINES), .W_X(CX_W), .W_Y(CY_W)
  ) u_win_cnt (
    .clk(clk), .rst_n(rst), .clr(sof_acc), .en(win_en),
    .x(win_x), .y(win_y), .last(win_last), .nxt_border(win_nb)
  );

  logic unused_ok;
  assign unused_ok = ^{in_x, in_y, in_nb, win_last};

`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == ST_DONE) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_cnt_q <= 16'd0;
    else      frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

  assign win_valid  = win_valid_q;
  assign border     = border_q;
  assign sof_err    = sof_err_q;
  assign frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb/tb_line_buf_ctrl.sv - directed self-checking bench for line_buf_ctrl on an 8x4 frame
module tb_line_buf_ctrl;

  localparam int LL  = 8;
  localparam int NL  = 4;
  localparam int CXW = 3;
  localparam int CYW = 2;
`ifdef FRAME_CNT_EN
  localparam int FC_ONE = 1;
`else
  localparam int FC_ONE = 0;
`endif

  logic clk = 1'b0, rst = 1'b0, sof = 1'b0, pix_valid = 1'b0, win_ready = 1'b1;
  logic pix_ready, shift_en, flush, win_valid, border, frame_done, sof_err;
  logic [CXW-1:0] win_x;
  logic [CYW-1:0] win_y;
  logic [15:0]    frame_cnt;

  line_buf_ctrl #(.LINE_LEN(LL), .NUM_LINES(NL), .CX_W(CXW), .CY_W(CYW)) dut (
    .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .win_ready(win_ready), .shift_en(shift_en), .flush(flush), .win_valid(win_valid),
    .win_x(win_x), .win_y(win_y), .border(border), .frame_done(frame_done),
    .sof_err(sof_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0] sr [0:18];
  logic [7:0] snap [0:8];
  logic [7:0] pix_data;
  int n_win, n_done, n_err, n_shift, exp_x, exp_y, order_bad, border_bad;
  int first_win_shift, done_shift, snap_seen, stall_bad, timed_out;
  logic first_border, snap_border, rs_wv;
  logic last_sh, last_fl, last_acc, last_pr;

  // One clock: called at negedge with inputs set; returns at next negedge
  task automatic tick();
    logic sa;
    #1;
    last_sh  = shift_en;
    last_fl  = flush;
    last_pr  = pix_ready;
    last_acc = pix_valid & pix_ready;
    sa       = sof & last_acc;
    @(posedge clk);
    #1;
    if (sa) begin
      n_shift = 1; n_win = 0; exp_x = 0; exp_y = 0;
    end else if (last_sh) begin
      n_shift++;
    end
    if (last_sh) begin
      for (int i = 18; i > 0; i--) sr[i] = sr[i-1];
      sr[0] = last_fl ? 8'd0 : pix_data;
    end
    if (last_sh && win_valid) begin
      if (n_win == 0) begin
        first_win_shift = n_shift;
        first_border    = border;
      end
      n_win++;
      if (int'(win_x) != exp_x || int'(win_y) != exp_y) order_bad++;
      if (border !== ((exp_x == 0) || (exp_x == LL-1) || (exp_y == 0) || (exp_y == NL-1))) border_bad++;
      if (exp_x == 3 && exp_y == 1) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            snap[r*3+c] = sr[18 - r*LL - c];
        snap_seen++;
        snap_border = border;
      end
      if (exp_x == LL-1) begin exp_x = 0; exp_y++; end
      else exp_x++;
    end
    if (frame_done) begin n_done++; done_shift = n_shift; end
    if (sof_err) n_err++;
    @(negedge clk);
  endtask

  task automatic drive_frame(input int stall_at, input int restart_at, input bit stop_flush);
    int sent = 0, stall_left = 0;
    bit restarted = 0, stalled = 0, rs_now;
    logic [CXW-1:0] hx;
    logic [CYW-1:0] hy;
    logic hv;
    n_done = 0; n_err = 0; order_bad = 0; border_bad = 0; snap_seen = 0; n_win = 0;
    first_win_shift = -1; done_shift = -1; stall_bad = 0; rs_wv = 1'bx;
    hx = '0; hy = '0; hv = 1'b0;
    for (int cyc = 0; cyc < 300 && n_done == 0; cyc++) begin
      if (stop_flush && flush === 1'b1) break;
      rs_now    = (sent == restart_at) && !restarted;
      pix_valid = (sent < LL*NL);
      sof       = (sent == 0) || rs_now;
      pix_data  = rs_now ? 8'd0 : 8'(sent);
      if (sent == stall_at && !stalled) begin
        stall_left = 5; stalled = 1;
        hx = win_x; hy = win_y; hv = win_valid;
      end
      win_ready = (stall_left == 0);
      tick();
      if (stall_left > 0) begin
        if (last_sh !== 1'b0 || win_x !== hx || win_y !== hy || win_valid !== hv) stall_bad++;
        stall_left--;
      end
      if (last_acc) begin
        if (rs_now) begin sent = 1; restarted = 1; rs_wv = win_valid; end
        else sent++;
      end
    end
    timed_out = (n_done == 0 && !(stop_flush && flush === 1'b1)) ? 1 : 0;
    pix_valid = 1'b0; sof = 1'b0; win_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pix_valid = 1'b1; sof = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({pix_ready, shift_en, flush, win_valid, border, frame_done, sof_err} !== 7'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0000000", {pix_ready, shift_en, flush, win_valid, border, frame_done, sof_err});
    end
    total++;
    if (win_x !== '0 || win_y !== '0 || frame_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_pos: got x=%0d y=%0d fc=%0d want 0 0 0", win_x, win_y, frame_cnt);
    end
    @(negedge clk);
    pix_valid = 1'b0; sof = 1'b0; rst = 1'b1;
    tick();
  endtask

  task automatic test_idle_no_sof();
    pix_valid = 1'b1; sof = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (last_pr !== 1'b1 || last_sh !== 1'b0 || win_valid !== 1'b0) begin
        bad++; $display("FAIL idle_discard: got ready=%b shift=%b wv=%b want 1 0 0", last_pr, last_sh, win_valid);
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    drive_frame(-1, -1, 0);
    total++;
    if (timed_out != 0) begin bad++; $display("FAIL full_timeout: got %0d want 0", timed_out); end
    total++;
    if (first_win_shift != 10) begin bad++; $display("FAIL first_win_shift: got %0d want 10", first_win_shift); end
    total++;
    if (first_border !== 1'b1) begin bad++; $display("FAIL first_border: got %b want 1", first_border); end
    total++;
    if (n_win != 32) begin bad++; $display("FAIL full_win_count: got %0d want 32", n_win); end
    total++;
    if (done_shift != 42) begin bad++; $display("FAIL done_shift: got %0d want 42", done_shift); end
    total++;
    if (n_done != 1) begin bad++; $display("FAIL full_done_count: got %0d want 1", n_done); end
    total++;
    if (order_bad != 0 || border_bad != 0) begin
      bad++; $display("FAIL full_order_border: got %0d/%0d want 0/0", order_bad, border_bad);
    end
    total++;
    if (int'(frame_cnt) != FC_ONE) begin bad++; $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, FC_ONE); end
    tick();
    total++;
    if (frame_done !== 1'b0) begin bad++; $display("FAIL done_pulse_width: got %b want 0", frame_done); end
  endtask

  task automatic test_ramp_taps();
    int exp_t [0:8];
    exp_t = '{2, 3, 4, 10, 11, 12, 18, 19, 20};
    drive_frame(-1, -1, 0);
    total++;
    if (snap_seen != 1) begin bad++; $display("FAIL tap_window_seen: got %0d want 1", snap_seen); end
    for (int i = 0; i < 9; i++) begin
      total++;
      if (int'(snap[i]) != exp_t[i]) begin
        bad++; $display("FAIL tap_%0d: got %0d want %0d", i, snap[i], exp_t[i]);
      end
    end
    total++;
    if (snap_border !== 1'b0) begin bad++; $display("FAIL tap_border: got %b want 0", snap_border); end
  endtask

  task automatic test_stall();
    drive_frame(16, -1, 0);
    total++;
    if (stall_bad != 0) begin bad++; $display("FAIL stall_frozen: got %0d bad cycles want 0", stall_bad); end
    total++;
    if (n_win != 32 || order_bad != 0) begin
      bad++; $display("FAIL stall_windows: got count=%0d order_bad=%0d want 32 0", n_win, order_bad);
    end
    total++;
    if (n_done != 1) begin bad++; $display("FAIL stall_done: got %0d want 1", n_done); end
  endtask

  task automatic test_sof_restart();
    drive_frame(-1, 20, 0);
    total++;
    if (n_err != 1) begin bad++; $display("FAIL sof_err_count: got %0d want 1", n_err); end
    total++;
    if (rs_wv !== 1'b0) begin bad++; $display("FAIL restart_win_valid: got %b want 0", rs_wv); end
    total++;
    if (n_win != 32 || order_bad != 0) begin
      bad++; $display("FAIL restart_windows: got count=%0d order_bad=%0d want 32 0", n_win, order_bad);
    end
    total++;
    if (n_done != 1 || first_win_shift != 10) begin
      bad++; $display("FAIL restart_done: got done=%0d first=%0d want 1 10", n_done, first_win_shift);
    end
  endtask

  task automatic test_reset_in_flush();
    drive_frame(-1, -1, 1);
    total++;
    if (flush !== 1'b1) begin bad++; $display("FAIL reach_flush: got %b want 1", flush); end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({pix_ready, shift_en, flush, win_valid, border, frame_done, sof_err} !== 7'b0) begin
      bad++; $display("FAIL flush_reset_flags: got %b want 0000000", {pix_ready, shift_en, flush, win_valid, border, frame_done, sof_err});
    end
    total++;
    if (win_x !== '0 || win_y !== '0 || frame_cnt !== 16'd0) begin
      bad++; $display("FAIL flush_reset_pos: got x=%0d y=%0d fc=%0d want 0 0 0", win_x, win_y, frame_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    drive_frame(-1, -1, 0);
    total++;
    if (n_win != 32 || n_done != 1 || first_win_shift != 10) begin
      bad++; $display("FAIL post_reset_frame: got win=%0d done=%0d first=%0d want 32 1 10", n_win, n_done, first_win_shift);
    end
    total++;
    if (int'(frame_cnt) != FC_ONE) begin bad++; $display("FAIL post_reset_frame_cnt: got %0d want %0d", frame_cnt, FC_ONE); end
  endtask

  initial begin
    for (int i = 0; i < 19; i++) sr[i] = 8'd0;
    for (int i = 0; i < 9; i++) snap[i] = 8'd0;
    pix_data = 8'd0;
    @(negedge clk);
    test_reset();
    test_idle_no_sof();
    test_full_frame();
    test_ramp_taps();
    test_stall();
    test_sof_restart();
    test_reset_in_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
